// File: rtl/bitboard_pkg.sv
// Shared constants and FSM encoding for the bitboard units.
package bitboard_pkg;

  // Checkers board: one bit per dark square
  localparam int unsigned BOARD_SQUARES = 32;
  localparam int unsigned SQ_IDX_W      = 5;

  // Scanner FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_ZERO = 2'd2;

endpackage

// File: rtl/bitboard_scanner_if.sv
// Mask-in / index-out handshake bundle for the bitboard scanner.
interface bitboard_scanner_if
  import bitboard_pkg::*;
#(
  parameter int unsigned WIDTH = BOARD_SQUARES,
  parameter int unsigned IDX_W = SQ_IDX_W
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_mask;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_index;
  logic             out_last;
  logic             out_none;
  logic [IDX_W:0]   out_seq;

  // Producer of masks and consumer of indices
  modport master (
    output in_valid, in_mask, abort, out_ready,
    input  in_ready, out_valid, out_index, out_last, out_none, out_seq
  );

  // The scanner itself
  modport slave (
    input  in_valid, in_mask, abort, out_ready,
    output in_ready, out_valid, out_index, out_last, out_none, out_seq
  );
endinterface

// File: rtl/lsb_index_32.sv
// Priority encoder: index of the lowest set bit, plus a single-bit-set flag.
module lsb_index_32
  import bitboard_pkg::*;
#(
  parameter int unsigned WIDTH = BOARD_SQUARES,
  parameter int unsigned IDX_W = SQ_IDX_W
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] index,
  output logic             one_hot
);

  // Walk from the top down so the lowest set bit is the last one to win
  always_comb begin
    index = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (vec[WIDTH-1-i]) begin
        index = IDX_W'(WIDTH - 1 - i);
      end
    end
  end

  // Exactly one bit set: nonzero and clearing the lowest bit leaves nothing
  always_comb begin
    one_hot = (vec != '0) && ((vec & (vec - WIDTH'(1))) == '0);
  end

endmodule

// File: rtl/bitboard_scanner.sv
// Sequential decomposer: emits the index of every set bit of a mask, one per beat.
module bitboard_scanner
  import bitboard_pkg::*;
#(
  parameter int unsigned WIDTH     = BOARD_SQUARES,
  parameter int unsigned IDX_W     = SQ_IDX_W,
  parameter bit          MSB_FIRST = 1'b0
) (
  input logic               clock,
  input logic               reset_n,
  bitboard_scanner_if.slave bus
);

  localparam logic [IDX_W:0] SeqOne = (IDX_W+1)'(1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [IDX_W:0]   seq_q, seq_d;

  logic [WIDTH-1:0] enc_in;
  logic [WIDTH-1:0] rem_cleared;
  logic [IDX_W-1:0] enc_idx;
  logic [IDX_W-1:0] scan_idx;
  logic             one_hot;

  // Present rem to the encoder in scan order (bit-reversed for descending scans)
  always_comb begin
    enc_in = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      enc_in[i] = MSB_FIRST ? rem_q[WIDTH-1-i] : rem_q[i];
    end
  end

  lsb_index_32 #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_enc (
    .vec     (enc_in),
    .index   (enc_idx),
    .one_hot (one_hot)
  );

  // Map the encoder result back to a square index and drop that square from rem
  always_comb begin
    if (MSB_FIRST) begin
      scan_idx    = IDX_W'(WIDTH - 1) - enc_idx;
      rem_cleared = rem_q & ~(WIDTH'(1) << scan_idx);
    end else begin
      scan_idx    = enc_idx;
      rem_cleared = rem_q & (rem_q - WIDTH'(1));
    end
  end

  // Outputs come straight from registered state, so they hold while stalled
  always_comb begin
    bus.in_ready  = (state_q == ST_IDLE);
    bus.out_valid = (state_q == ST_SCAN) || (state_q == ST_ZERO);
    bus.out_index = '0;
    bus.out_last  = 1'b0;
    bus.out_none  = 1'b0;
    bus.out_seq   = '0;
    if (state_q == ST_SCAN) begin
      bus.out_index = scan_idx;
      bus.out_last  = one_hot;
      bus.out_seq   = seq_q;
    end else if (state_q == ST_ZERO) begin
      bus.out_last = 1'b1;
      bus.out_none = 1'b1;
    end
  end

  // Next-state: accept in IDLE, step on each beat, abort wins over a handshake
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    seq_d   = seq_q;
    case (state_q)
      ST_IDLE: begin
        // abort is meaningless here; an incoming mask is still taken
        if (bus.in_valid) begin
          rem_d   = bus.in_mask;
          seq_d   = '0;
          state_d = (bus.in_mask != '0) ? ST_SCAN : ST_ZERO;
        end
      end
      ST_SCAN: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
          rem_d   = '0;
          seq_d   = '0;
        end else if (bus.out_ready) begin
          rem_d = rem_cleared;
          seq_d = seq_q + SeqOne;
          if (one_hot) begin
            state_d = ST_IDLE;
            seq_d   = '0;
          end
        end
      end
      ST_ZERO: begin
        if (bus.abort || bus.out_ready) begin
          state_d = ST_IDLE;
          rem_d   = '0;
          seq_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        rem_d   = '0;
        seq_d   = '0;
      end
    endcase
  end

  // State registers, asynchronously cleared
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      seq_q   <= seq_d;
    end
  end

  // A stalled beat must not change under the consumer
  property p_stall_stable;
    @(posedge clock) disable iff (!reset_n)
      (bus.out_valid && !bus.out_ready && !bus.abort) |=>
        (bus.out_valid && $stable(bus.out_index) && $stable(bus.out_seq) &&
         $stable(bus.out_last) && $stable(bus.out_none));
  endproperty
  a_stall_stable: assert property (p_stall_stable);

  // Never accept while a scan is in flight
  property p_no_overlap;
    @(posedge clock) disable iff (!reset_n) !(bus.in_ready && bus.out_valid);
  endproperty
  a_no_overlap: assert property (p_no_overlap);

endmodule

// File: tb/tb_bitboard_scanner.sv
// Self-checking bench: ascending and descending scanners against a queue model.
module tb_bitboard_scanner;

  typedef struct packed {
    logic [4:0] idx;
    logic       last;
    logic       none;
    logic [5:0] seq;
  } beat_t;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  bitboard_scanner_if #(.WIDTH(32), .IDX_W(5)) a_if ();
  bitboard_scanner_if #(.WIDTH(32), .IDX_W(5)) d_if ();

  bitboard_scanner #(.WIDTH(32), .IDX_W(5), .MSB_FIRST(1'b0)) u_asc (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (a_if)
  );

  bitboard_scanner #(.WIDTH(32), .IDX_W(5), .MSB_FIRST(1'b1)) u_desc (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (d_if)
  );

  int total = 0;
  int bad = 0;
  beat_t expq0[$];
  beat_t expq1[$];
  int gotq0[$];
  int gotq1[$];
  int expl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a mask becomes the list of its set squares in scan order
  task automatic push_mask(input int d, input logic [31:0] m);
    beat_t b;
    int k = 0;
    int s = 0;
    int sq;
    for (int i = 0; i < 32; i++) if (m[i]) k++;
    if (k == 0) begin
      b = '{idx: 5'd0, last: 1'b1, none: 1'b1, seq: 6'd0};
      if (d == 0) expq0.push_back(b); else expq1.push_back(b);
    end else begin
      for (int i = 0; i < 32; i++) begin
        sq = (d == 0) ? i : 31 - i;
        if (m[sq]) begin
          b = '{idx: 5'(sq), last: (s == k - 1), none: 1'b0, seq: 6'(s)};
          if (d == 0) expq0.push_back(b); else expq1.push_back(b);
          s++;
        end
      end
    end
  endtask

  task automatic mon(input int d, input logic ov, input logic ir, input logic iv,
                     input logic ordy, input logic ab, input logic [4:0] idx,
                     input logic lst, input logic nn, input logic [5:0] sq,
                     input logic [31:0] m);
    int n;
    beat_t e;
    n = (d == 0) ? expq0.size() : expq1.size();
    check((d == 0) ? "asc.in_ready" : "desc.in_ready", 64'(ir), 64'(n == 0));
    check((d == 0) ? "asc.out_valid" : "desc.out_valid", 64'(ov), 64'(n != 0));
    if (ov && n > 0) begin
      e = (d == 0) ? expq0[0] : expq1[0];
      check((d == 0) ? "asc.beat{idx,last,none,seq}" : "desc.beat{idx,last,none,seq}",
            64'({idx, lst, nn, sq}), 64'(e));
      if (ordy) begin
        if (d == 0) gotq0.push_back(int'(idx)); else gotq1.push_back(int'(idx));
      end
      if (ab) begin
        if (d == 0) expq0.delete(); else expq1.delete();
      end else if (ordy) begin
        if (d == 0) void'(expq0.pop_front()); else void'(expq1.pop_front());
      end
    end
    if (iv && ir) push_mask(d, m);
  endtask

  // Compare process: outputs are settled at the falling edge
  always @(negedge clock) begin
    if (reset_n) begin
      mon(0, a_if.out_valid, a_if.in_ready, a_if.in_valid, a_if.out_ready, a_if.abort,
          a_if.out_index, a_if.out_last, a_if.out_none, a_if.out_seq, a_if.in_mask);
      mon(1, d_if.out_valid, d_if.in_ready, d_if.in_valid, d_if.out_ready, d_if.abort,
          d_if.out_index, d_if.out_last, d_if.out_none, d_if.out_seq, d_if.in_mask);
    end
  end

  always @(negedge reset_n) begin
    expq0.delete();
    expq1.delete();
  end

  // Called at posedge+1; presents the mask for exactly one edge
  task automatic send(input int d, input logic [31:0] m);
    if (d == 0) begin a_if.in_valid = 1'b1; a_if.in_mask = m; end
    else begin d_if.in_valid = 1'b1; d_if.in_mask = m; end
    @(posedge clock);
    #1;
    if (d == 0) begin a_if.in_valid = 1'b0; a_if.in_mask = 32'hDEAD_BEEF; end
    else begin d_if.in_valid = 1'b0; d_if.in_mask = 32'hDEAD_BEEF; end
  endtask

  task automatic wait_idle(input int d);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (d == 0 ? (a_if.in_ready && !a_if.out_valid) : (d_if.in_ready && !d_if.out_valid)) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_within_budget", 64'(ok), 64'd1);
    @(posedge clock);
    #1;
  endtask

  task automatic chk_got(input string name, input int d);
    int n;
    n = (d == 0) ? gotq0.size() : gotq1.size();
    check({name, ".count"}, 64'(n), 64'(expl.size()));
    for (int i = 0; i < n && i < expl.size(); i++) begin
      check({name, ".index"}, 64'((d == 0) ? gotq0[i] : gotq1[i]), 64'(expl[i]));
    end
    gotq0.delete();
    gotq1.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_if.in_valid = 1'b0; a_if.in_mask = '0; a_if.abort = 1'b0; a_if.out_ready = 1'b1;
    d_if.in_valid = 1'b0; d_if.in_mask = '0; d_if.abort = 1'b0; d_if.out_ready = 1'b1;

    // Asynchronous reset and its output values
    #1 reset_n = 1'b0;
    #2;
    check("reset.in_ready", 64'(a_if.in_ready), 64'd1);
    check("reset.out_valid", 64'(a_if.out_valid), 64'd0);
    check("reset.out_index", 64'(a_if.out_index), 64'd0);
    check("reset.out_flags", 64'({a_if.out_last, a_if.out_none}), 64'd0);
    check("reset.out_seq", 64'(a_if.out_seq), 64'd0);
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    @(posedge clock);
    #1;

    // 0x29: squares 0,3,5
    send(0, 32'h0000_0029);
    wait_idle(0);
    expl = '{0, 3, 5};
    chk_got("mask29", 0);

    // All-zero mask: single none beat
    send(0, 32'h0000_0000);
    @(negedge clock);
    check("zero.none_last_idx", 64'({a_if.out_none, a_if.out_last, a_if.out_index}),
          64'({1'b1, 1'b1, 5'd0}));
    wait_idle(0);
    expl = '{0};
    chk_got("mask0", 0);

    // Full board with a consumer stalling every other cycle
    a_if.out_ready = 1'b0;
    send(0, 32'hFFFF_FFFF);
    for (int i = 0; i < 100 && gotq0.size() < 32; i++) begin
      a_if.out_ready = ~a_if.out_ready;
      @(posedge clock);
      #1;
    end
    a_if.out_ready = 1'b1;
    wait_idle(0);
    expl.delete();
    for (int i = 0; i < 32; i++) expl.push_back(i);
    chk_got("maskFFFFFFFF", 0);

    // Top square alone
    send(0, 32'h8000_0000);
    wait_idle(0);
    expl = '{31};
    chk_got("mask80000000", 0);

    // Descending scan
    send(1, 32'h8000_0001);
    wait_idle(1);
    expl = '{31, 0};
    chk_got("desc80000001", 1);

    // Abort after the index-12 handshake, then a fresh mask
    a_if.out_ready = 1'b0;
    send(0, 32'h0000_F000);
    a_if.out_ready = 1'b1;
    @(posedge clock);
    #1;
    a_if.out_ready = 1'b0;
    a_if.abort = 1'b1;
    @(posedge clock);
    #1;
    a_if.abort = 1'b0;
    a_if.out_ready = 1'b1;
    @(negedge clock);
    check("abort.in_ready", 64'(a_if.in_ready), 64'd1);
    check("abort.out_valid", 64'(a_if.out_valid), 64'd0);
    @(posedge clock);
    #1;
    send(0, 32'h0000_0002);
    wait_idle(0);
    expl = '{12, 1};
    chk_got("abort_then_2", 0);

    // abort in IDLE does not block an accept
    a_if.abort = 1'b1;
    send(0, 32'h0000_0004);
    a_if.abort = 1'b0;
    wait_idle(0);
    expl = '{2};
    chk_got("idle_abort", 0);

    // Reset pulsed mid-cycle after three beats of 0xFF
    send(0, 32'h0000_00FF);
    repeat (3) @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    check("midreset.out_valid", 64'(a_if.out_valid), 64'd0);
    check("midreset.in_ready", 64'(a_if.in_ready), 64'd1);
    #3 reset_n = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    expl = '{0, 1, 2};
    chk_got("midreset", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bitboard_scanner.md
Name: bitboard_scanner

Overview:
- Sequential decomposer for 32-bit checkers bitboards: one bit per dark square.
- Accepts a mask assembled by the datapath's bitwise logic (OR of piece/move masks).
- Emits the index of every set bit, one per handshake, lowest index first.
- Sits between the processor's bitboard registers and the move-generation / motor-command logic, which consumes one square at a time.

Parameters:
- WIDTH, 32, mask width in bits (squares on the board).
- IDX_W, 5, index width; must equal ceil(log2(WIDTH)).
- MSB_FIRST, 0, scan order: 0 = ascending index, 1 = descending index.

Ports:
- clock  input  1  single system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_mask is valid.
- in_ready  output  1  block is idle and can accept a mask.
- in_mask  input  WIDTH  bitboard to decompose.
- abort  input  1  synchronous: drop the current scan and return to IDLE.
- out_valid  output  1  out_index is valid.
- out_ready  input  1  consumer accepts the current index.
- out_index  output  IDX_W  square index of the current set bit.
- out_last  output  1  current beat is the final beat for this mask.
- out_none  output  1  accepted mask was all zeros; out_index = 0 on this beat.
- out_seq  output  IDX_W+1  0-based beat number within the current mask.

Behaviour:
- Reset, asynchronous on reset_n low:
  - State = IDLE, remaining mask = 0, seq = 0.
  - Outputs: in_ready = 1, out_valid = 0, out_index = 0, out_last = 0, out_none = 0, out_seq = 0.
  - Reset asserted mid-scan discards the scan with no further beats.
  - After reset_n deasserts, the first accept can occur on the next rising edge.
- States: IDLE, SCAN, ZERO.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid && in_ready at edge N:
    - Register in_mask into rem, seq := 0.
    - Go to SCAN if in_mask != 0, else ZERO.
  - out_valid rises in cycle N+1 (latency 1). in_ready = 0 from cycle N+1.
- SCAN:
  - out_valid = 1.
  - out_index = priority-encoded lowest set bit of rem (highest if MSB_FIRST).
  - out_last = 1 iff popcount(rem) == 1.
  - out_seq = seq.
  - On out_valid && out_ready: clear the reported bit in rem and increment seq.
    - Ascending clear: rem & (rem - 1).
    - Descending clear: clear bit out_index.
  - If the beat had out_last = 1, go to IDLE; in_ready = 1 next cycle.
  - Without out_ready, all out_* hold stable (no change while stalled).
- ZERO:
  - One beat: out_valid = 1, out_none = 1, out_last = 1, out_index = 0, out_seq = 0.
  - Handshake returns to IDLE.
- Throughput:
  - One index per cycle while out_ready is held high.
  - A mask with k set bits takes k beats; the next mask is accepted no earlier than 1 cycle after the last beat.
  - No input/output overlap: in_ready = 0 in SCAN and ZERO.
- abort:
  - In SCAN or ZERO: go to IDLE at the next edge, out_valid = 0 next cycle, no further beats.
  - abort takes priority over a simultaneous out handshake; that beat still counts as consumed by the consumer.
  - In IDLE: abort is ignored, and an in handshake on the same cycle is still accepted.
- in_mask is ignored when in_valid = 0 or in_ready = 0.
- Boundary masks:
  - 0xFFFFFFFF produces 32 beats (indices 0..31), out_seq 0..31, out_last only on index 31.
  - 0x80000000 produces a single beat, index 31, out_last = 1.
- Index arithmetic is unsigned.
- seq never exceeds WIDTH-1 on a valid beat; its width is IDX_W+1 so that WIDTH itself is representable.

Decomposition:
- Shared package bitboard_pkg:
  - Constants: BOARD_SQUARES = 32, SQ_IDX_W = 5.
  - State encoding localparams: ST_IDLE, ST_SCAN, ST_ZERO.
  - Shared by the scanner and future bitboard units.
- One combinational sub-module: lsb_index_32.
  - WIDTH-bit priority encoder: index of the lowest set bit, plus a "one-hot" flag for out_last detection.
  - Instantiated once; MSB_FIRST is handled by bit-reversing its input and output.

Test Plan:
- Reset, then mask 0x00000029 with out_ready = 1 -> beats index 5, 3, 0 in descending order? No: ascending beats are index 0, 3, 5; out_seq 0, 1, 2; out_last only on index 5; in_ready = 1 in the cycle after the index-5 beat.
- Mask 0x00000000 -> single beat: out_none = 1, out_last = 1, out_index = 0; returns to IDLE.
- Mask 0xFFFFFFFF with out_ready toggling 1/0 every cycle -> 32 beats, indices 0..31 in order; out_index stable across every stall cycle; no lost or duplicated beats.
- MSB_FIRST = 1, mask 0x80000001 -> beats index 31 then 0; out_last on index 0.
- Mask 0x0000F000; abort asserted after the index-12 handshake -> no further beats; in_ready = 1 the next cycle; new mask 0x2 then yields a single beat, index 1.
- reset_n pulsed low asynchronously (mid-cycle) during a scan of 0x000000FF after 3 beats -> out_valid = 0 and in_ready = 1 immediately; no remaining indices emitted after release.
